// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window reader: tap count, FSM states and
// the row/column to tap-index mapping used to lay out the 3x3 window.
package sobel_pkg;

    localparam int SOBEL_TAPS = 9;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH,
        DONE
    } state_t;

    function automatic int tap_idx(input int r, input int c);
        return 3 * r + c;
    endfunction

endpackage

// File: rtl/sobel_window_reader_if.sv
// FIFO-facing signals of the window reader: FWFT grayscale FIFO on the input
// side, Sobel input FIFO on the output side.
interface sobel_window_reader_if #(
    parameter int DWIDTH = 8
);
    import sobel_pkg::*;

    logic [DWIDTH-1:0]            in_dout;
    logic                         in_empty;
    logic                         in_rd_en;
    logic [SOBEL_TAPS*DWIDTH-1:0] out_din;
    logic                         out_border;
    logic                         out_wr_en;
    logic                         out_full;

    modport master (
        input  in_dout, in_empty, out_full,
        output in_rd_en, out_din, out_border, out_wr_en
    );

    modport slave (
        output in_dout, in_empty, out_full,
        input  in_rd_en, out_din, out_border, out_wr_en
    );

endinterface

// File: rtl/line_buffer.sv
// One image row of pixels in a circular RAM. The read is prefetched so that
// dout always holds mem[addr] for the column the next shift will write.
module line_buffer #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 720,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic [AW-1:0]     addr,
    input  logic              shift,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout
);
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_addr;

    // On a shift the column pointer moves on, so fetch the following column.
    always_comb begin
        rd_addr = addr;
        if (shift) begin
            rd_addr = (addr == AW'(DEPTH - 1)) ? '0 : addr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (shift) begin
            mem[addr] <= din;
        end
        dout <= mem[rd_addr];
    end

endmodule

// File: rtl/sobel_window_reader.sv
// Pops grayscale pixels, keeps two rows of history and pushes one 3x3 window
// plus border flag per pixel, in raster order of the centre pixel.
module sobel_window_reader
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int DWIDTH     = 8
) (
    input logic                   clock,
    input logic                   reset,
    sobel_window_reader_if.master bus
);
    localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    state_t                       state_reg, state_next;
    logic [CNT_W-1:0]             in_cnt_reg, out_cnt_reg;
    logic [COL_W-1:0]             col_reg, ccol_reg;
    logic [ROW_W-1:0]             crow_reg;
    logic                         out_valid_reg, out_border_reg;
    logic [SOBEL_TAPS*DWIDTH-1:0] out_din_reg;
    logic                         reg_free, step, rd, load, frame_clear, border_next;
    logic [DWIDTH-1:0]            pixel;
    logic [2:0][DWIDTH-1:0]       col_in;
    wire  [1:0][DWIDTH-1:0]       lb_in, lb_out;
    wire  [SOBEL_TAPS*DWIDTH-1:0] win_next;

    assign reg_free = !out_valid_reg || !bus.out_full;
    assign step     = !reset && reg_free && state_reg != DONE &&
                      (state_reg == FLUSH || !bus.in_empty);
    assign rd       = step && state_reg != FLUSH;
    assign pixel    = (state_reg == FLUSH) ? '0 : bus.in_dout;

    assign bus.in_rd_en   = rd;
    assign bus.out_wr_en  = out_valid_reg && !bus.out_full;
    assign bus.out_din    = out_din_reg;
    assign bus.out_border = out_border_reg;

    // Buffer 0 returns the pixel one row above, buffer 1 the one two rows above.
    assign lb_in[0] = pixel;
    assign lb_in[1] = lb_out[0];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lb
            line_buffer #(
                .DWIDTH(DWIDTH),
                .DEPTH (IMG_WIDTH)
            ) u_lb (
                .clock(clock),
                .addr (col_reg),
                .shift(step),
                .din  (lb_in[gi]),
                .dout (lb_out[gi])
            );
        end
    endgenerate

    always_comb begin
        col_in[0] = lb_out[1];
        col_in[1] = lb_out[0];
        col_in[2] = pixel;
    end

    // Each window row slides left; the new right-hand column enters at c=2.
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            localparam int LO = tap_idx(gi, 0) * DWIDTH;
            logic [3*DWIDTH-1:0] row_reg;

            assign win_next[LO +: 3*DWIDTH] = {col_in[gi], row_reg[3*DWIDTH-1:DWIDTH]};

            always_ff @(posedge clock) begin
                if (reset) begin
                    row_reg <= '0;
                end else if (step) begin
                    row_reg <= win_next[LO +: 3*DWIDTH];
                end
            end
        end
    endgenerate

    assign border_next = (crow_reg == '0) || (crow_reg == ROW_W'(IMG_HEIGHT - 1)) ||
                         (ccol_reg == '0) || (ccol_reg == COL_W'(IMG_WIDTH - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        load        = 1'b0;
        frame_clear = 1'b0;
        case (state_reg)
            FILL: begin
                if (step && in_cnt_reg == CNT_W'(IMG_WIDTH)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (step) begin
                    load = 1'b1;
                    if (in_cnt_reg == CNT_W'(NPIX - 1)) begin
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (step) begin
                    load = 1'b1;
                    if (out_cnt_reg == CNT_W'(NPIX - 1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                // The last window leaves this cycle (or already has).
                if (reg_free) begin
                    state_next  = FILL;
                    frame_clear = 1'b1;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_cnt_reg     <= '0;
            out_cnt_reg    <= '0;
            col_reg        <= '0;
            ccol_reg       <= '0;
            crow_reg       <= '0;
            out_valid_reg  <= 1'b0;
            out_din_reg    <= '0;
            out_border_reg <= 1'b0;
        end else begin
            if (frame_clear) begin
                in_cnt_reg  <= '0;
                out_cnt_reg <= '0;
                col_reg     <= '0;
                ccol_reg    <= '0;
                crow_reg    <= '0;
            end else begin
                if (rd) begin
                    in_cnt_reg <= in_cnt_reg + 1'b1;
                end
                if (step) begin
                    col_reg <= (col_reg == COL_W'(IMG_WIDTH - 1)) ? '0 : col_reg + 1'b1;
                end
                if (load) begin
                    out_cnt_reg <= out_cnt_reg + 1'b1;
                    if (ccol_reg == COL_W'(IMG_WIDTH - 1)) begin
                        ccol_reg <= '0;
                        crow_reg <= (crow_reg == ROW_W'(IMG_HEIGHT - 1)) ? '0 : crow_reg + 1'b1;
                    end else begin
                        ccol_reg <= ccol_reg + 1'b1;
                    end
                end
            end
            if (reg_free) begin
                out_valid_reg <= load;
            end
            if (load) begin
                out_din_reg    <= win_next;
                out_border_reg <= border_next;
            end
        end
    end

endmodule
